control_actor: RTL
==================

# control_actor

Parametrised grid-actor controller: the tile-stepping motion core shared by Pac-Man and the ghosts. It converts a direction request into tile-by-tile movement on the maze grid at a programmable step rate. It holds a buffered turn request, and checks walls through an external maze-map port with 1-cycle read latency. It outputs position, facing, moving status and an animation frame index; the sprite lookup downstream uses facing and frame.

## Interface
- `DEFAULT_X`, 13: reset tile column.
- `DEFAULT_Y`, 18: reset tile row.
- `RESET_DIR`, 3 (left): facing and current direction at reset.
- `X_W`, 8: column width.
- `Y_W`, 7: row width.
- `GRID_W`, 28: columns; x range is 0..GRID_W-1.
- `GRID_H`, 31: rows; y range is 0..GRID_H-1.
- `STEP_DIV`, 8: clock cycles per step tick; must be ≥6.
- `PEND_STEPS`, 4: step ticks a buffered turn survives before it expires.
- `ANIM_FRAMES`, 2: animation frames; `AF_W` = max(1, clog2(ANIM_FRAMES)).
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: step-tick counting allowed.
- `dir_in` in 3: 0 none, 1 up, 2 down, 3 left, 4 right; the codes 5–7 are treated as none.
- `wall_in` in 1: maze-map answer for the tile queried on the previous cycle; 1 means wall.
- `query_x` out X_W, `query_y` out Y_W: tile presented to the maze map.
- `x_out` out X_W, `y_out` out Y_W: current tile.
- `facing` out 3: last direction actually moved or accepted.
- `moving` out 1: the last step attempt succeeded.
- `anim_frame` out AF_W: animation frame index.
- `step_done` out 1: one-cycle pulse, asserted on the cycle the new position first appears.

## Operation
- **Direction buffer.**
  - A valid nonzero `dir_in` is sampled every cycle into `pending`, and the expiry count is reloaded to PEND_STEPS.
  - The expiry count decrements on each step tick in which the turn is rejected. At 0, `pending` clears to none.
  - An accepted turn clears `pending`.
- **Step tick.**
  - `tick_cnt` counts 0..STEP_DIV-1 while `enable`=1 and holds while `enable`=0.
  - A tick occurs when `tick_cnt`=STEP_DIV-1.
  - A tick is consumed only in state WAIT; a tick arriving in any other state is dropped.
- **Target tile.** Computed from the current tile and a direction:
  - up: y-1; down: y+1; left: x-1; right: x+1.
  - Both axes wrap: left at x=0 gives GRID_W-1, right at GRID_W-1 gives 0; y wraps the same way with GRID_H.
- **FSM** (states WAIT, QT, WT, QF, WF, DONE):
  - WAIT, on tick: go to QT if `pending`≠none, else to QF.
  - QT: `query` = target(pending), then go to WT.
  - WT: if `wall_in`=0, accept the turn: direction ← pending, facing ← pending, position ← target, then go to DONE. Otherwise go to QF.
  - QF: if cur_dir=none, record a blocked step and go to DONE. Otherwise `query` = target(cur_dir), then go to WF.
  - WF: if `wall_in`=0, position ← target, then go to DONE. Otherwise the step is blocked: position holds and cur_dir is kept (retried next tick), then go to DONE.
  - DONE: `step_done`=1 for this cycle, then go to WAIT.
- **Success.** On a successful step, `moving`←1 and `anim_frame` ← (anim_frame+1) mod ANIM_FRAMES.
- **Blocked.** On a blocked step, `moving`←0 and `anim_frame` holds.
- **`enable` low mid-step.** A step already in progress finishes normally.
- **Reset** (synchronous, `reset_n`=0 at a rising edge): this overrides everything, including a mid-step FSM, and the FSM returns to WAIT.
  - `x_out`=DEFAULT_X, `y_out`=DEFAULT_Y.
  - `facing` = cur_dir = RESET_DIR.
  - `pending`=none, expiry count = 0.
  - `moving`=0, `anim_frame`=0, `step_done`=0.
  - `query_x`=0, `query_y`=0.
  - `tick_cnt`=0.

## Timing
- All outputs are registered.
- `query_x`/`query_y` change on the edge that enters QT or QF. The maze map returns `wall_in` valid on the following cycle (WT or WF).
- Tick seen in WAIT at cycle T:
  - Turn accepted: new `x_out`/`y_out` and `step_done` at T+3.
  - Turn rejected: new position at T+5.
  - No pending turn: new position at T+3.
- `dir_in` arriving on the same cycle as the QT edge is not used for that step. Its `pending` update still takes effect.
- `moving`, `facing` and `anim_frame` update together with the position, on the edge into DONE.

## Test plan
- **Reset.** Hold `reset_n`=0 for 2 cycles, then release. Require x=13, y=18, facing=3, moving=0, step_done=0. Run with all walls open and no input: the first step_done occurs STEP_DIV+3 cycles after reset release, with x=12, moving=1, anim_frame=1.
- **Buffered turn.** At x=13,y=18 heading left, pulse dir_in=1 for one cycle. Keep the tile above walled for 2 ticks, then open it. Require two left steps (T+5 each), then y=17, facing=1, pending cleared.
- **Turn expiry.** Pulse dir_in=2 with the tile below walled permanently. After 4 ticks, require pending=none and subsequent steps of T+3 latency (QT skipped).
- **Wrap-around.** At x=0 heading left with an open tunnel, require x=27 on the next step_done. At x=27 heading right, require x=0.
- **Blocked.** With the forward wall set and no pending turn, require position held, moving=0, anim_frame unchanged, step_done still pulsed. Then drop `enable` mid-step: the step completes, and no further steps occur until `enable`=1.
- **Mid-step reset.** Assert `reset_n`=0 during WT. Require full reset values on the next edge and no step_done.

Source files
------------

// File: rtl/control_actor.sv
// control_actor: tile-stepping motion core for a maze actor (player or ghost).
// A step-rate divider produces ticks. On each tick the FSM first tries the
// buffered turn, then the current heading. Each attempt queries the maze map,
// whose answer arrives one cycle later. All outputs come straight from registers.
module control_actor #(
  parameter int DEFAULT_X   = 13,
  parameter int DEFAULT_Y   = 18,
  parameter int RESET_DIR   = 3,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int GRID_W      = 28,
  parameter int GRID_H      = 31,
  parameter int STEP_DIV    = 8,
  parameter int PEND_STEPS  = 4,
  parameter int ANIM_FRAMES = 2,
  localparam int AF_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [2:0]      dir_in,
  input  logic            wall_in,
  output logic [X_W-1:0]  query_x,
  output logic [Y_W-1:0]  query_y,
  output logic [X_W-1:0]  x_out,
  output logic [Y_W-1:0]  y_out,
  output logic [2:0]      facing,
  output logic            moving,
  output logic [AF_W-1:0] anim_frame,
  output logic            step_done
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam int EXP_W = $clog2(PEND_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);
  localparam logic [AF_W-1:0]  AF_MAX  = AF_W'(ANIM_FRAMES - 1);

  localparam logic [2:0] D_NONE  = 3'd0;
  localparam logic [2:0] D_UP    = 3'd1;
  localparam logic [2:0] D_DOWN  = 3'd2;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  typedef enum logic [2:0] {S_WAIT, S_QT, S_WT, S_QF, S_WF, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;
  logic [2:0]       pend_q, pend_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [2:0]       turn_q, turn_d;
  logic [2:0]       cur_dir_q, cur_dir_d;
  logic [2:0]       facing_q, facing_d;
  logic [X_W-1:0]   x_q, x_d, qx_q, qx_d;
  logic [Y_W-1:0]   y_q, y_d, qy_q, qy_d;
  logic             moving_q, moving_d;
  logic [AF_W-1:0]  anim_q, anim_d, anim_inc;
  logic             done_q, done_d;
  logic             dir_vld, turn_acc, turn_rej;

  // Neighbouring column in direction d, wrapping at the grid edges.
  function automatic logic [X_W-1:0] tgt_x(input logic [X_W-1:0] x, input logic [2:0] d);
    tgt_x = x;
    if (d == D_LEFT)
      tgt_x = (x == '0) ? X_W'(GRID_W - 1) : x - 1'b1;
    else if (d == D_RIGHT)
      tgt_x = (x == X_W'(GRID_W - 1)) ? '0 : x + 1'b1;
  endfunction

  // Neighbouring row in direction d, wrapping at the grid edges.
  function automatic logic [Y_W-1:0] tgt_y(input logic [Y_W-1:0] y, input logic [2:0] d);
    tgt_y = y;
    if (d == D_UP)
      tgt_y = (y == '0) ? Y_W'(GRID_H - 1) : y - 1'b1;
    else if (d == D_DOWN)
      tgt_y = (y == Y_W'(GRID_H - 1)) ? '0 : y + 1'b1;
  endfunction

  assign dir_vld  = (dir_in != D_NONE) && (dir_in <= D_RIGHT);
  assign anim_inc = (anim_q == AF_MAX) ? '0 : anim_q + 1'b1;

  // State register; reset drops any step in flight back to WAIT.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_WAIT;
    else          state_q <= state_d;
  end

  // Position, heading, turn buffer, query and tick divider registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      pend_q     <= D_NONE;
      exp_q      <= '0;
      turn_q     <= D_NONE;
      cur_dir_q  <= 3'(RESET_DIR);
      facing_q   <= 3'(RESET_DIR);
      x_q        <= X_W'(DEFAULT_X);
      y_q        <= Y_W'(DEFAULT_Y);
      qx_q       <= '0;
      qy_q       <= '0;
      moving_q   <= 1'b0;
      anim_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
      exp_q      <= exp_d;
      turn_q     <= turn_d;
      cur_dir_q  <= cur_dir_d;
      facing_q   <= facing_d;
      x_q        <= x_d;
      y_q        <= y_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      moving_q   <= moving_d;
      anim_q     <= anim_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: tick divider, step FSM, then the turn buffer.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    pend_d     = pend_q;
    exp_d      = exp_q;
    turn_d     = turn_q;
    cur_dir_d  = cur_dir_q;
    facing_d   = facing_q;
    x_d        = x_q;
    y_d        = y_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    moving_d   = moving_q;
    anim_d     = anim_q;
    turn_acc   = 1'b0;
    turn_rej   = 1'b0;

    // The tick is registered so the FSM sees a clean one-cycle pulse.
    if (enable) begin
      tick_d     = (tick_cnt_q == CNT_MAX);
      tick_cnt_d = (tick_cnt_q == CNT_MAX) ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      S_WAIT: begin
        if (tick_q) begin
          if (pend_q != D_NONE) begin
            // Latch the turn so a new dir_in cannot change it mid-step.
            state_d = S_QT;
            turn_d  = pend_q;
            qx_d    = tgt_x(x_q, pend_q);
            qy_d    = tgt_y(y_q, pend_q);
          end else begin
            state_d = S_QF;
            if (cur_dir_q != D_NONE) begin
              qx_d = tgt_x(x_q, cur_dir_q);
              qy_d = tgt_y(y_q, cur_dir_q);
            end
          end
        end
      end
      S_QT: state_d = S_WT;
      S_WT: begin
        if (!wall_in) begin
          turn_acc  = 1'b1;
          cur_dir_d = turn_q;
          facing_d  = turn_q;
          x_d       = qx_q;
          y_d       = qy_q;
          moving_d  = 1'b1;
          anim_d    = anim_inc;
          state_d   = S_DONE;
        end else begin
          turn_rej = 1'b1;
          state_d  = S_QF;
          if (cur_dir_q != D_NONE) begin
            qx_d = tgt_x(x_q, cur_dir_q);
            qy_d = tgt_y(y_q, cur_dir_q);
          end
        end
      end
      S_QF: begin
        if (cur_dir_q == D_NONE) begin
          moving_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d = S_WF;
        end
      end
      S_WF: begin
        // A blocked heading is kept so the next tick retries it.
        if (!wall_in) begin
          x_d      = qx_q;
          y_d      = qy_q;
          facing_d = cur_dir_q;
          moving_d = 1'b1;
          anim_d   = anim_inc;
        end else begin
          moving_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase

    // A fresh request always wins over accept/expiry bookkeeping.
    if (dir_vld) begin
      pend_d = dir_in;
      exp_d  = EXP_W'(PEND_STEPS);
    end else if (turn_acc) begin
      pend_d = D_NONE;
      exp_d  = '0;
    end else if (turn_rej) begin
      if (exp_q <= EXP_W'(1)) begin
        pend_d = D_NONE;
        exp_d  = '0;
      end else begin
        exp_d = exp_q - 1'b1;
      end
    end
  end

  assign done_d = (state_d == S_DONE);

  assign query_x    = qx_q;
  assign query_y    = qy_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign facing     = facing_q;
  assign moving     = moving_q;
  assign anim_frame = anim_q;
  assign step_done  = done_q;

endmodule
